ttc_trigger_dispatcher: RTL
===========================

# ttc_trigger_dispatcher

Upstream stage of the channel acquisition controller: converts raw TTC Level-1 accepts (L1A) and TTC broadcast commands into a qualified one-cycle `trigger` pulse with a latched trigger type and a 24-bit trigger number. It sits between the TTC decoder and the controller's trigger/`acq_ready` interface. It drops L1As that arrive while the acquisition path is not ready, and keeps saturating counts of the dropped triggers for status readout.

## Interface
- `HOLDOFF_FIXED`, 2: post-trigger holdoff in cycles (range 1..15). Used when `TRIG_HOLDOFF_EN` is undefined.
- `clk` in 1: 40 MHz TTC clock.
- `reset` in 1: synchronous, active-high.
- `ttc_l1a` in 1: one-cycle L1A strobe.
- `ttc_brdcst_strobe` in 1: broadcast command valid.
- `ttc_brdcst` in 6: broadcast command.
- `acq_ready` in 1: controller idle and ready to accept a trigger.
- `holdoff_cfg` in 16: programmable holdoff in cycles. Used only with `TRIG_HOLDOFF_EN`.
- `trigger` out 1: one-cycle qualified trigger pulse.
- `trig_type` out 5: one-hot type. Bit 0 muon fill, bit 1 laser, bit 2 pedestal, bit 3 async readout, bit 4 reserved (always 0).
- `trig_num` out 24: number of the issued trigger.
- `missed_cnt` out 16: saturating count of dropped L1As.
- `missed_flag` out 1: sticky; set on any dropped L1A.
- `clr_status` in 1: clears `missed_cnt` and `missed_flag`.
- `state` out 3: one-hot FSM state (bit 0 IDLE, bit 1 ISSUE, bit 2 HOLDOFF).

## Operation
- Reset values:
  - `state`=3'b001, `trigger`=0, `trig_type`=0, `trig_num`=0, `missed_cnt`=0, `missed_flag`=0.
  - Internal next-number counter=1, latched type code=0.
- Broadcast decode applies only when `ttc_brdcst_strobe`=1:
  - `ttc_brdcst[5:3]`=3'b101 sets the type code to `ttc_brdcst[2:0]`. Codes 1..4 map to one-hot bits 0..3. Codes 0 and 5..7 store "none".
  - `ttc_brdcst`=6'b000010 is an event counter reset (ECR): the next-number counter is set to 1.
  - All other commands are ignored.
- FSM:
  - IDLE: an L1A is accepted when `acq_ready`=1 and the type code is not "none". An accepted L1A moves the FSM to ISSUE; otherwise it is dropped.
  - ISSUE: one cycle. The FSM then moves to HOLDOFF.
  - HOLDOFF: the FSM counts holdoff cycles, then returns to IDLE.
- Dropped L1A: an L1A is dropped if it arrives in IDLE with `acq_ready`=0 or with type "none", or if it arrives in ISSUE or HOLDOFF. Each drop increments `missed_cnt` (saturating at 16'hFFFF) and sets `missed_flag`.
- Accepted L1A:
  - `trig_type` and `trig_num` load on entry to ISSUE from the type code and the next-number counter.
  - The counter then increments and wraps from 24'hFFFFFF to 24'h000000.
  - Both outputs hold until the next accepted L1A.
- Simultaneous events:
  - ECR with an L1A in the same cycle: ECR takes effect first, so the trigger carries number 1 and the counter becomes 2.
  - Type-set broadcast with an L1A in the same cycle: the L1A uses the previously latched type.
  - `clr_status` with a drop in the same cycle: the clear wins, so the result is `missed_cnt`=0 and `missed_flag`=0.
- Reset mid-holdoff: the FSM returns to IDLE immediately and all counters reinitialise.

## Timing
- L1A sampled at cycle N (with `acq_ready` sampled at N) gives `trigger`=1 at N+1. `trig_type` and `trig_num` are valid from N+1.
- `trigger` is exactly one cycle wide.
- Holdoff length H:
  - HOLDOFF spans cycles N+2 .. N+1+H.
  - The earliest next accepted L1A is at N+2+H.
- Broadcast effects are visible to an L1A on the following cycle.
- Status counters update one cycle after the L1A that is dropped.

## Configuration
- `TRIG_HOLDOFF_EN` defined:
  - H = `holdoff_cfg`, sampled at entry to HOLDOFF.
  - `holdoff_cfg`=0 is treated as 1.
- `TRIG_HOLDOFF_EN` undefined:
  - H = `HOLDOFF_FIXED`.
  - `holdoff_cfg` is ignored.

## Test plan
- Reset, type broadcast 6'b101001, `acq_ready`=1, L1A at cycle 10 -> `trigger` at 11, `trig_type`=5'b00001, `trig_num`=1. A second L1A at cycle 20 -> `trig_num`=2.
- L1A with `acq_ready`=0 -> no `trigger`, `missed_cnt`=1, `missed_flag`=1. Then `clr_status` -> both 0.
- L1A at cycle N, second L1A at N+2 with H=2 -> second L1A dropped (`missed_cnt`=1). Third L1A at N+4 -> accepted.
- ECR together with an L1A -> `trig_num`=1. The next accepted L1A -> `trig_num`=2.
- Preload the next-number counter to 24'hFFFFFF via L1As/force, issue two L1As -> `trig_num`=24'hFFFFFF, then 24'h000000.
- With `TRIG_HOLDOFF_EN`, `holdoff_cfg`=5 -> HOLDOFF lasts 5 cycles. `holdoff_cfg`=0 -> 1 cycle. Reset asserted mid-holdoff -> `state`=3'b001 next cycle.

Source files
------------

// File: rtl/ttc_trigger_dispatcher_if.sv
// Trigger handoff between the TTC trigger dispatcher (master) and the
// acquisition controller (slave): qualified trigger pulse, type, number, ready.
interface ttc_trigger_dispatcher_if;
  logic        trigger;
  logic [4:0]  trig_type;
  logic [23:0] trig_num;
  logic        acq_ready;

  modport master (
    output trigger,
    output trig_type,
    output trig_num,
    input  acq_ready
  );

  modport slave (
    input  trigger,
    input  trig_type,
    input  trig_num,
    output acq_ready
  );
endinterface

// File: rtl/ttc_trigger_dispatcher.sv
// Qualifies TTC L1As into one-cycle triggers with latched type/number and keeps drop statistics.
// Optional macro TRIG_HOLDOFF_EN selects holdoff_cfg instead of HOLDOFF_FIXED as holdoff length.
module ttc_trigger_dispatcher #(
  parameter int unsigned HOLDOFF_FIXED = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ttc_l1a,
  input  logic                             ttc_brdcst_strobe,
  input  logic [5:0]                       ttc_brdcst,
  input  logic [15:0]                      holdoff_cfg,
  input  logic                             clr_status,
  ttc_trigger_dispatcher_if.master         trig_if,
  output logic [15:0]                      missed_cnt,
  output logic                             missed_flag,
  output logic [2:0]                       state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_ISSUE   = 3'b010,
    ST_HOLDOFF = 3'b100
  } state_e;

  state_e      state_q, state_d;
  logic        trigger_q, trigger_d;
  logic [4:0]  trig_type_q, trig_type_d;
  logic [23:0] trig_num_q, trig_num_d;
  logic [23:0] next_num_q, next_num_d;
  logic [2:0]  type_code_q, type_code_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] missed_cnt_q, missed_cnt_d;
  logic        missed_flag_q, missed_flag_d;

  logic        type_set;
  logic        ecr;
  logic        accept;
  logic        drop;
  logic [23:0] num_base;
  logic [15:0] hold_len;
  logic [4:0]  type_onehot;

`ifdef TRIG_HOLDOFF_EN
  assign hold_len = (holdoff_cfg == 16'd0) ? 16'd1 : holdoff_cfg;
`else
  logic unused_holdoff_cfg;
  assign unused_holdoff_cfg = ^holdoff_cfg;
  assign hold_len = 16'(HOLDOFF_FIXED);
`endif

  assign type_set = ttc_brdcst_strobe && (ttc_brdcst[5:3] == 3'b101);
  assign ecr      = ttc_brdcst_strobe && (ttc_brdcst == 6'b000010);
  // ECR acts before a coincident L1A, so the L1A numbers from the reset value.
  assign num_base = ecr ? 24'd1 : next_num_q;
  assign accept   = (state_q == ST_IDLE) && ttc_l1a && trig_if.acq_ready &&
                    (type_code_q != 3'd0);
  assign drop     = ttc_l1a && !accept;

  always_comb begin
    type_onehot = '0;
    case (type_code_q)
      3'd1:    type_onehot = 5'b00001;
      3'd2:    type_onehot = 5'b00010;
      3'd3:    type_onehot = 5'b00100;
      3'd4:    type_onehot = 5'b01000;
      default: type_onehot = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    trigger_d     = 1'b0;
    trig_type_d   = trig_type_q;
    trig_num_d    = trig_num_q;
    next_num_d    = num_base;
    type_code_d   = type_code_q;
    hold_cnt_d    = hold_cnt_q;
    missed_cnt_d  = missed_cnt_q;
    missed_flag_d = missed_flag_q;

    if (type_set) begin
      type_code_d = (ttc_brdcst[2:0] >= 3'd1 && ttc_brdcst[2:0] <= 3'd4) ?
                    ttc_brdcst[2:0] : 3'd0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_ISSUE;
          trigger_d   = 1'b1;
          trig_type_d = type_onehot;
          trig_num_d  = num_base;
          next_num_d  = num_base + 24'd1;
        end
      end
      ST_ISSUE: begin
        state_d    = ST_HOLDOFF;
        hold_cnt_d = hold_len - 16'd1;
      end
      ST_HOLDOFF: begin
        if (hold_cnt_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr_status) begin
      missed_cnt_d  = '0;
      missed_flag_d = 1'b0;
    end else if (drop) begin
      missed_flag_d = 1'b1;
      if (missed_cnt_q != '1) begin
        missed_cnt_d = missed_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      trigger_q     <= 1'b0;
      trig_type_q   <= '0;
      trig_num_q    <= '0;
      next_num_q    <= 24'd1;
      type_code_q   <= '0;
      hold_cnt_q    <= '0;
      missed_cnt_q  <= '0;
      missed_flag_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      trigger_q     <= trigger_d;
      trig_type_q   <= trig_type_d;
      trig_num_q    <= trig_num_d;
      next_num_q    <= next_num_d;
      type_code_q   <= type_code_d;
      hold_cnt_q    <= hold_cnt_d;
      missed_cnt_q  <= missed_cnt_d;
      missed_flag_q <= missed_flag_d;
    end
  end

  assign trig_if.trigger   = trigger_q;
  assign trig_if.trig_type = trig_type_q;
  assign trig_if.trig_num  = trig_num_q;
  assign missed_cnt        = missed_cnt_q;
  assign missed_flag       = missed_flag_q;
  assign state             = state_q;

endmodule
